// File: rtl/ntt_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : ntt_stream_unpacker
// Purpose  : Captures (I)NTT processor output beats into a small FIFO and
//            serialises them as OUT_LANES-wide coefficient groups on a
//            valid/ready stream, with overflow and address-order checking.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_stream_unpacker #(
    parameter int LOG_CORE_COUNT  = 4,
    parameter int COEFF_WIDTH     = 30,
    parameter int COEFFS_PER_WORD = 2,
    parameter int OUT_LANES       = 1,
    parameter int LOG_N           = 12,
    parameter int ADDR_WIDTH      = 9,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                                        clk,
    input  logic                                                        rst_n,
    input  logic                                                        in_valid,
    input  logic [ADDR_WIDTH-1:0]                                       in_addr,
    input  logic [(1<<LOG_CORE_COUNT)*2*COEFF_WIDTH*COEFFS_PER_WORD-1:0] in_data,
    output logic                                                        out_valid,
    input  logic                                                        out_ready,
    output logic [OUT_LANES*COEFF_WIDTH-1:0]                            out_data,
    output logic [LOG_N-1:0]                                            out_index,
    output logic                                                        out_last,
    output logic [$clog2(FIFO_DEPTH):0]                                 fifo_level,
    output logic                                                        overflow,
    output logic                                                        seq_error
);

    localparam int CORES   = 1 << LOG_CORE_COUNT;
    localparam int WORD_W  = COEFF_WIDTH * COEFFS_PER_WORD;
    localparam int BEAT_W  = CORES * 2 * WORD_W;
    localparam int BEAT_C  = CORES * 2 * COEFFS_PER_WORD;
    localparam int GROUPS  = BEAT_C / OUT_LANES;
    localparam int GRP_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int GROUP_W = OUT_LANES * COEFF_WIDTH;
    localparam int BEATS   = (1 << LOG_N) / BEAT_C;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    localparam logic [GRP_W-1:0]      LAST_GRP  = GRP_W'(GROUPS - 1);
    localparam logic [LVL_W-1:0]      FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BEATS - 1);
    localparam logic [LOG_N-1:0]      LAST_IDX  = LOG_N'((1 << LOG_N) - OUT_LANES);
    localparam logic [LOG_N-1:0]      IDX_STEP  = LOG_N'(OUT_LANES);

    logic [BEAT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [GRP_W-1:0]      grp_q, grp_d;
    logic [LOG_N-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d;
    logic                  overflow_q, overflow_d;
    logic                  seq_error_q, seq_error_d;

    logic                  full;
    logic                  accept;
    logic                  pop;
    logic                  push;
    logic [BEAT_W-1:0]     head;
    logic [GROUP_W-1:0]    head_grp [GROUPS];

    // Serial coefficient order equals flat bit order, so group g is a plain slice.
    assign head = mem_q[rd_ptr_q];

    generate
        for (genvar g = 0; g < GROUPS; g++) begin : g_group
            assign head_grp[g] = head[g*GROUP_W +: GROUP_W];
        end
    endgenerate

    always_comb begin
        full        = (level_q == FULL_LVL);
        out_valid   = (level_q != '0);
        accept      = out_valid && out_ready;
        pop         = accept && (grp_q == LAST_GRP);
        // A full FIFO can still take a beat when its head leaves on the same edge.
        push        = in_valid && (!full || pop);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        grp_d       = grp_q;
        idx_d       = idx_q;
        exp_addr_d  = exp_addr_q;
        overflow_d  = overflow_q;
        seq_error_d = seq_error_q;

        if (accept) begin
            grp_d = pop ? '0 : grp_q + 1'b1;
            idx_d = idx_q + IDX_STEP;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d   = wr_ptr_q + 1'b1;
            exp_addr_d = (in_addr == LAST_ADDR) ? '0 : in_addr + 1'b1;
            if (in_addr != exp_addr_q) begin
                seq_error_d = 1'b1;
            end
        end else if (in_valid) begin
            overflow_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            grp_q       <= '0;
            idx_q       <= '0;
            exp_addr_q  <= '0;
            overflow_q  <= 1'b0;
            seq_error_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            grp_q       <= grp_d;
            idx_q       <= idx_d;
            exp_addr_q  <= exp_addr_d;
            overflow_q  <= overflow_d;
            seq_error_q <= seq_error_d;
        end
    end

    // Beat storage needs no reset; the level counter says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data   = head_grp[grp_q];
    assign out_index  = idx_q;
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign seq_error  = seq_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_stream_unpacker
// Purpose  : Scoreboard bench for ntt_stream_unpacker with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_stream_unpacker;

    localparam int CW     = 30;
    localparam int BEAT_C = 64;
    localparam int N      = 4096;
    localparam int BEATS  = 64;
    localparam int DEPTH  = 4;
    localparam int BW     = BEAT_C * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [8:0]    in_addr = '0;
    logic [BW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [CW-1:0] out_data;
    logic [11:0]   out_index;
    logic          out_last;
    logic [2:0]    fifo_level;
    logic          overflow;
    logic          seq_error;

    always #5 clk = ~clk;

    ntt_stream_unpacker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .seq_error  (seq_error)
    );

    typedef struct {
        logic [CW-1:0] d;
        int            idx;
        bit            last;
    } item_t;

    item_t sb[$];
    int    m_beats, m_left, m_idx, m_exp;
    bit    m_ovf, m_seq;
    int    tests, fails;
    bit    mon_en;
    int    n_acc, n_last;
    bit    prev_stall;
    logic [CW-1:0] prev_d;
    logic [11:0]   prev_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: a queue of beats, each emitting BEAT_C coefficients in flat bit order.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_beats = 0; m_left = BEAT_C; m_idx = 0; m_exp = 0;
            m_ovf = 0; m_seq = 0;
            sb.delete();
        end else begin
            bit acc, pop, push;
            acc  = (m_beats > 0) && out_ready;
            pop  = acc && (m_left == 1);
            push = in_valid && ((m_beats < DEPTH) || pop);
            if (acc) m_left--;
            if (pop) begin
                m_beats--;
                m_left = BEAT_C;
            end
            if (push) begin
                m_beats++;
                if (int'(in_addr) != m_exp) m_seq = 1;
                m_exp = (int'(in_addr) + 1) % BEATS;
                for (int k = 0; k < BEAT_C; k++) begin
                    item_t it;
                    it.d    = in_data[k*CW +: CW];
                    it.idx  = m_idx;
                    it.last = (m_idx == N - 1);
                    sb.push_back(it);
                    m_idx = (m_idx + 1) % N;
                end
            end else if (in_valid) begin
                m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", out_valid, (m_beats > 0));
            chk("fifo_level", fifo_level, m_beats);
            chk("overflow", overflow, m_ovf);
            chk("seq_error", seq_error, m_seq);
            if (prev_stall && out_valid) begin
                chk("hold_data", out_data, prev_d);
                chk("hold_index", out_index, prev_i);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got data %0h, required no transfer", out_data);
                end else begin
                    item_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_index", out_index, e.idx);
                    chk("out_last", out_last, e.last);
                    n_acc++;
                    if (out_last) n_last++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_i     = out_index;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] b;
        for (int k = 0; k < BEAT_C; k++) b[k*CW +: CW] = CW'($urandom);
        return b;
    endfunction

    task automatic send(input int addr, input logic [BW-1:0] b);
        in_valid = 1'b1;
        in_addr  = 9'(addr);
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget, output int cyc);
        out_ready = 1'b1;
        cyc = 0;
        while (m_beats > 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        if (m_beats > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats left after %0d cycles, required 0", m_beats, cyc);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [BW-1:0] b;
        int cyc, n0, l0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_seq_error", seq_error, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Single beat with coefficient k = k+1
        for (int k = 0; k < BEAT_C; k++) b[k*CW +: CW] = CW'(k + 1);
        out_ready = 1'b1;
        n0 = n_acc;
        send(0, b);
        chk("single_level", fifo_level, 1);
        chk("single_first", out_data, 1);
        drain(200, cyc);
        chk("single_cycles", cyc, 64);
        chk("single_count", n_acc - n0, 64);

        // Backpressure pattern 1,0,0,1
        n0 = n_acc;
        send(m_exp, rand_beat());
        cyc = 0;
        while (m_beats > 0 && cyc < 400) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
            cyc++;
        end
        drain(10, cyc);
        chk("bp_count", n_acc - n0, 64);

        // Full FIFO with a pop on the same edge as a push
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(m_exp, rand_beat());
        chk("full_level", fifo_level, 4);
        out_ready = 1'b1;
        cyc = 0;
        while (m_left != 1 && cyc < 100) begin
            tick();
            cyc++;
        end
        send(m_exp, rand_beat());
        chk("fullpop_level", fifo_level, 4);
        chk("fullpop_overflow", overflow, 0);
        drain(600, cyc);

        // Overflow: five beats into a stalled FIFO
        n0 = n_acc;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(m_exp, rand_beat());
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        drain(600, cyc);
        chk("ovf_count", n_acc - n0, 256);

        // Full polynomial, then an out-of-order address
        pulse_reset();
        l0 = n_last;
        for (int i = 0; i < BEATS; i++) begin
            send(i, rand_beat());
            drain(100, cyc);
        end
        chk("poly_seq_error", seq_error, 0);
        chk("poly_index_wrap", out_index, 0);
        chk("poly_last_count", n_last - l0, 1);
        send(0, rand_beat());
        send(5, rand_beat());
        chk("bad_addr_seq_error", seq_error, 1);
        drain(300, cyc);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 24 == 0);
            in_addr   = ($urandom % 10 == 0) ? 9'($urandom % BEATS) : 9'(m_exp);
            in_data   = rand_beat();
            out_ready = ($urandom % 4 != 0);
            tick();
        end
        in_valid = 1'b0;
        drain(2000, cyc);

        // Asynchronous reset mid-beat
        out_ready = 1'b1;
        send(m_exp, rand_beat());
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_level", fifo_level, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_index", out_index, 0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
